rgb_to_yuv_encoder: RTL and testbench



---
 rtl/rgb_to_yuv_encoder_pkg.sv | 50 +++++
 rtl/rgb_to_yuv_math.sv | 31 +++
 rtl/rgb_to_yuv_encoder.sv | 182 ++++++++++++++++++
 tb/tb_rgb_to_yuv_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared types and constants for the RGB->YUV 4:2:2 encoder: FSM states,
// default SRAM plane bases, conversion coefficients and scalar helpers.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
    S_WAIT0, S_WAIT1,
    S_CALC,
    S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V
  } enc_state_t;

  localparam logic [17:0] RGB_BASE_DEF   = 18'd146944;
  localparam logic [17:0] Y_BASE_DEF     = 18'd0;
  localparam logic [17:0] U_BASE_DEF     = 18'd38400;
  localparam logic [17:0] V_BASE_DEF     = 18'd57600;
  localparam int          NUM_GROUPS_DEF = 19200;

  localparam int Y_R = 66;
  localparam int Y_G = 129;
  localparam int Y_B = 25;
  localparam int Y_RND = 128;
  localparam int Y_OFS = 16;

  localparam int U_R = -38;
  localparam int U_G = -74;
  localparam int U_B = 112;
  localparam int V_R = 112;
  localparam int V_G = -94;
  localparam int V_B = -18;
  localparam int C_RND = 256;
  localparam int C_OFS = 128;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return v[7:0];
  endfunction

  function automatic int luma(input int r, input int g, input int b);
    return ((Y_R * r + Y_G * g + Y_B * b + Y_RND) >>> 8) + Y_OFS;
  endfunction

  // Chroma works on pair sums, so the extra bit of the sum is folded into the shift.
  function automatic int chroma(input int cr, input int cg, input int cb,
                                input int rs, input int gs, input int bs);
    return ((cr * rs + cg * gs + cb * bs + C_RND) >>> 9) + C_OFS;
  endfunction

endpackage

// File: rtl/rgb_to_yuv_math.sv
// Combinational conversion of one horizontal pixel pair: two luma samples
// plus one decimated U/V sample, all clamped to 8 bits.
module rgb_to_yuv_math
  import rgb_to_yuv_encoder_pkg::*;
(
  input  logic [7:0] i_r0,
  input  logic [7:0] i_g0,
  input  logic [7:0] i_b0,
  input  logic [7:0] i_r1,
  input  logic [7:0] i_g1,
  input  logic [7:0] i_b1,
  output logic [7:0] o_y0,
  output logic [7:0] o_y1,
  output logic [7:0] o_u,
  output logic [7:0] o_v
);

  int w_rs;
  int w_gs;
  int w_bs;

  assign w_rs = int'(i_r0) + int'(i_r1);
  assign w_gs = int'(i_g0) + int'(i_g1);
  assign w_bs = int'(i_b0) + int'(i_b1);

  assign o_y0 = clamp8(luma(int'(i_r0), int'(i_g0), int'(i_b0)));
  assign o_y1 = clamp8(luma(int'(i_r1), int'(i_g1), int'(i_b1)));
  assign o_u  = clamp8(chroma(U_R, U_G, U_B, w_rs, w_gs, w_bs));
  assign o_v  = clamp8(chroma(V_R, V_G, V_B, w_rs, w_gs, w_bs));

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// Streams packed RGB groups (4 pixels in 6 words) out of SRAM, converts them
// to YUV 4:2:2 and writes the Y, U and V planes back, 13 cycles per group.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter logic [17:0] RGB_BASE   = RGB_BASE_DEF,
  parameter logic [17:0] Y_BASE     = Y_BASE_DEF,
  parameter logic [17:0] U_BASE     = U_BASE_DEF,
  parameter logic [17:0] V_BASE     = V_BASE_DEF,
  parameter int          NUM_GROUPS = NUM_GROUPS_DEF
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        M_start,
  output logic        M_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int GW = $clog2(NUM_GROUPS + 1);

  enc_state_t    r_state;
  enc_state_t    w_state_next;
  logic [17:0]   r_rgb_addr;
  logic [17:0]   r_y_addr;
  logic [17:0]   r_u_addr;
  logic [17:0]   r_v_addr;
  logic [GW-1:0] r_group;
  logic          r_done;
  logic [15:0]   r_w [6];
  logic [7:0]    r_y [4];
  logic [7:0]    r_uc [2];
  logic [7:0]    r_vc [2];
  logic [7:0]    w_y [4];
  logic [7:0]    w_uc [2];
  logic [7:0]    w_vc [2];
  logic          w_last;
  logic          w_cap_en;
  logic [2:0]    w_cap_idx;

  assign w_last = (r_group == GW'(NUM_GROUPS - 1));

  // Pair gi uses words 3gi..3gi+2: {R,G}, {B,R'}, {G',B'}.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pair
      rgb_to_yuv_math u_math (
        .i_r0 (r_w[3*gi][15:8]),
        .i_g0 (r_w[3*gi][7:0]),
        .i_b0 (r_w[3*gi+1][15:8]),
        .i_r1 (r_w[3*gi+1][7:0]),
        .i_g1 (r_w[3*gi+2][15:8]),
        .i_b1 (r_w[3*gi+2][7:0]),
        .o_y0 (w_y[2*gi]),
        .o_y1 (w_y[2*gi+1]),
        .o_u  (w_uc[gi]),
        .o_v  (w_vc[gi])
      );
    end
  endgenerate

  // Read data trails the address by two cycles, so word k lands two states later.
  always_comb begin
    w_cap_en  = 1'b1;
    w_cap_idx = 3'd0;
    case (r_state)
      S_RD2:   w_cap_idx = 3'd0;
      S_RD3:   w_cap_idx = 3'd1;
      S_RD4:   w_cap_idx = 3'd2;
      S_RD5:   w_cap_idx = 3'd3;
      S_WAIT0: w_cap_idx = 3'd4;
      S_WAIT1: w_cap_idx = 3'd5;
      default: w_cap_en  = 1'b0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_word
      always_ff @(posedge CLOCK_50_I or posedge Reset) begin
        if (Reset) r_w[gi] <= '0;
        else if (w_cap_en && w_cap_idx == 3'(gi)) r_w[gi] <= SRAM_read_data;
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (M_start) w_state_next = S_RD0;
      S_RD0:   w_state_next = S_RD1;
      S_RD1:   w_state_next = S_RD2;
      S_RD2:   w_state_next = S_RD3;
      S_RD3:   w_state_next = S_RD4;
      S_RD4:   w_state_next = S_RD5;
      S_RD5:   w_state_next = S_WAIT0;
      S_WAIT0: w_state_next = S_WAIT1;
      S_WAIT1: w_state_next = S_CALC;
      S_CALC:  w_state_next = S_WR_Y0;
      S_WR_Y0: w_state_next = S_WR_Y1;
      S_WR_Y1: w_state_next = S_WR_U;
      S_WR_U:  w_state_next = S_WR_V;
      S_WR_V:  w_state_next = w_last ? S_IDLE : S_RD0;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_rgb_addr <= RGB_BASE;
      r_y_addr   <= Y_BASE;
      r_u_addr   <= U_BASE;
      r_v_addr   <= V_BASE;
      r_group    <= '0;
      r_done     <= 1'b0;
      for (int i = 0; i < 4; i++) r_y[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        r_uc[i] <= '0;
        r_vc[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (M_start) begin
          r_rgb_addr <= RGB_BASE;
          r_y_addr   <= Y_BASE;
          r_u_addr   <= U_BASE;
          r_v_addr   <= V_BASE;
          r_group    <= '0;
        end
        S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5: r_rgb_addr <= r_rgb_addr + 18'd1;
        S_CALC: begin
          r_y  <= w_y;
          r_uc <= w_uc;
          r_vc <= w_vc;
        end
        S_WR_Y0, S_WR_Y1: r_y_addr <= r_y_addr + 18'd1;
        S_WR_U: r_u_addr <= r_u_addr + 18'd1;
        S_WR_V: begin
          r_v_addr <= r_v_addr + 18'd1;
          if (w_last) r_done <= 1'b1;
          else r_group <= r_group + GW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SRAM_address    = r_rgb_addr;
    SRAM_write_data = 16'h0000;
    SRAM_we_n       = 1'b1;
    case (r_state)
      S_WR_Y0: begin
        SRAM_address    = r_y_addr;
        SRAM_write_data = {r_y[0], r_y[1]};
        SRAM_we_n       = 1'b0;
      end
      S_WR_Y1: begin
        SRAM_address    = r_y_addr;
        SRAM_write_data = {r_y[2], r_y[3]};
        SRAM_we_n       = 1'b0;
      end
      S_WR_U: begin
        SRAM_address    = r_u_addr;
        SRAM_write_data = {r_uc[0], r_uc[1]};
        SRAM_we_n       = 1'b0;
      end
      S_WR_V: begin
        SRAM_address    = r_v_addr;
        SRAM_write_data = {r_vc[0], r_vc[1]};
        SRAM_we_n       = 1'b0;
      end
      default: ;
    endcase
  end

  assign M_done = r_done;

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed bench for rgb_to_yuv_encoder: SRAM model with 2-cycle read latency,
// shortened frame ending at address 262143, cycle-exact address sequencing.
module tb_rgb_to_yuv_encoder;
  import rgb_to_yuv_encoder_pkg::*;

  localparam int          NG        = 120;
  localparam logic [17:0] RGB_B     = 18'd261424;
  localparam int          OUT_WORDS = 76800;

  logic        clk;
  logic        rst;
  logic        M_start;
  logic        M_done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  logic [15:0] rgb_mem [0:6*NG-1];
  logic [15:0] out_mem [0:OUT_WORDS-1];
  logic [15:0] rd_p1;
  logic        clr_out;
  int          n_writes = 0;
  int          bad_wr   = 0;
  int          total    = 0;
  int          bad      = 0;

  rgb_to_yuv_encoder #(
    .RGB_BASE   (RGB_B),
    .NUM_GROUPS (NG)
  ) dut (
    .CLOCK_50_I      (clk),
    .Reset           (rst),
    .M_start         (M_start),
    .M_done          (M_done),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_p1 <= (SRAM_address >= RGB_B) ? rgb_mem[SRAM_address - RGB_B] : 16'h0000;
    SRAM_read_data <= rd_p1;
    if (clr_out) begin
      for (int i = 0; i < OUT_WORDS; i++) out_mem[i] <= 16'hDEAD;
    end else if (!SRAM_we_n) begin
      n_writes <= n_writes + 1;
      if (SRAM_address < 18'(OUT_WORDS)) out_mem[SRAM_address] <= SRAM_write_data;
      else bad_wr <= bad_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rgb(input logic [15:0] val);
    for (int i = 0; i < 6 * NG; i++) rgb_mem[i] = val;
  endtask

  task automatic clear_out();
    @(negedge clk) clr_out = 1'b1;
    @(negedge clk) clr_out = 1'b0;
  endtask

  task automatic scan(input int lo, input int n, input logic [15:0] val, output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) if (out_mem[lo + i] !== val) errs++;
  endtask

  // Cycle-exact expectation of address, we_n and done for one frame; optional
  // mid-run start pulse; optional early return at a given cycle.
  task automatic run_frame(input int abort_at, input bit midstart,
                           output int seq_err, output int wr_cnt);
    int          g;
    int          ph;
    int          w0;
    logic [17:0] exp_a;
    seq_err = 0;
    w0 = n_writes;
    @(negedge clk) M_start = 1'b1;
    @(negedge clk) M_start = 1'b0;
    for (int c = 0; c <= 13 * NG; c++) begin
      if (c == abort_at) return;
      g  = c / 13;
      ph = c % 13;
      if (c == 13 * NG) begin
        if (M_done !== 1'b1 || SRAM_we_n !== 1'b1) seq_err++;
      end else begin
        if (M_done !== 1'b0) seq_err++;
        if (SRAM_we_n !== ((ph >= 9) ? 1'b0 : 1'b1)) seq_err++;
        exp_a = SRAM_address;
        if (ph < 6) exp_a = 18'(int'(RGB_B) + 6 * g + ph);
        else if (ph == 9 || ph == 10) exp_a = 18'(2 * g + ph - 9);
        else if (ph == 11) exp_a = 18'(38400 + g);
        else if (ph == 12) exp_a = 18'(57600 + g);
        if (SRAM_address !== exp_a) seq_err++;
      end
      if (midstart && c == 40) M_start = 1'b1;
      if (midstart && c == 41) M_start = 1'b0;
      @(negedge clk);
    end
    if (M_done !== 1'b0) seq_err++;
    wr_cnt = n_writes - w0;
  endtask

  int seq_err;
  int wr_cnt;
  int errs;

  initial begin
    rst     = 1'b1;
    M_start = 1'b0;
    clr_out = 1'b0;
    fill_rgb(16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_we_n", 32'(SRAM_we_n), 32'h1);
    chk("rst_addr", 32'(SRAM_address), 32'(RGB_B));
    chk("rst_wdata", 32'(SRAM_write_data), 32'h0);
    chk("rst_done", 32'(M_done), 32'h0);
    rst = 1'b0;

    // Black frame, with a stray start pulse while busy.
    clear_out();
    run_frame(-1, 1'b1, seq_err, wr_cnt);
    chk("black_seq", 32'(seq_err), 32'd0);
    chk("black_writes", 32'(wr_cnt), 32'(4 * NG));
    scan(0, 2 * NG, 16'h1010, errs);
    chk("black_y", 32'(errs), 32'd0);
    scan(38400, NG, 16'h8080, errs);
    chk("black_u", 32'(errs), 32'd0);
    scan(57600, NG, 16'h8080, errs);
    chk("black_v", 32'(errs), 32'd0);
    chk("black_oob", 32'(bad_wr), 32'd0);

    // White frame.
    fill_rgb(16'hFFFF);
    clear_out();
    run_frame(-1, 1'b0, seq_err, wr_cnt);
    chk("white_seq", 32'(seq_err), 32'd0);
    scan(0, 2 * NG, 16'hEBEB, errs);
    chk("white_y", 32'(errs), 32'd0);
    scan(38400, NG, 16'h8080, errs);
    chk("white_u", 32'(errs), 32'd0);
    scan(57600, NG, 16'h8080, errs);
    chk("white_v", 32'(errs), 32'd0);

    // Group 0 pure red; group 1 only pixel 0 red.
    fill_rgb(16'h0000);
    rgb_mem[0] = 16'hFF00; rgb_mem[1] = 16'h00FF; rgb_mem[2] = 16'h0000;
    rgb_mem[3] = 16'hFF00; rgb_mem[4] = 16'h00FF; rgb_mem[5] = 16'h0000;
    rgb_mem[6] = 16'hFF00;
    clear_out();
    run_frame(-1, 1'b0, seq_err, wr_cnt);
    chk("red_seq", 32'(seq_err), 32'd0);
    chk("red_y0", 32'(out_mem[0]), 32'h5252);
    chk("red_y1", 32'(out_mem[1]), 32'h5252);
    chk("red_u", 32'(out_mem[38400]), 32'h5A5A);
    chk("red_v", 32'(out_mem[57600]), 32'hF0F0);
    chk("mix_y2", 32'(out_mem[2]), 32'h5210);
    chk("mix_y3", 32'(out_mem[3]), 32'h1010);
    chk("mix_u", 32'(out_mem[38401]), 32'h6D80);
    chk("mix_v", 32'(out_mem[57601]), 32'hB880);

    // Group 0 pure blue; reset during WR_U of group 100, then restart.
    fill_rgb(16'h0000);
    rgb_mem[0] = 16'h0000; rgb_mem[1] = 16'hFF00; rgb_mem[2] = 16'h00FF;
    rgb_mem[3] = 16'h0000; rgb_mem[4] = 16'hFF00; rgb_mem[5] = 16'h00FF;
    run_frame(100 * 13 + 11, 1'b0, seq_err, wr_cnt);
    chk("pre_abort_we_n", 32'(SRAM_we_n), 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(SRAM_we_n), 32'h1);
    chk("abort_state", 32'(dut.r_state), 32'(S_IDLE));
    chk("abort_addr", 32'(SRAM_address), 32'(RGB_B));
    chk("abort_done", 32'(M_done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(M_done), 32'h0);
    clear_out();
    run_frame(-1, 1'b0, seq_err, wr_cnt);
    chk("blue_seq", 32'(seq_err), 32'd0);
    chk("blue_writes", 32'(wr_cnt), 32'(4 * NG));
    chk("blue_y", 32'(out_mem[0]), 32'h2929);
    chk("blue_u", 32'(out_mem[38400]), 32'hF0F0);
    chk("blue_v", 32'(out_mem[57600]), 32'h6E6E);
    chk("final_oob", 32'(bad_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
